// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: per-stage enables, hazard bubbles,
// front-end flush, memory-wait timeout and saturating hazard statistics.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             start,
  input  logic             halt,
  input  logic             id_ex_memread,
  input  logic [4:0]       id_ex_rd,
  input  logic [4:0]       if_id_rs1,
  input  logic [4:0]       if_id_rs2,
  input  logic             mem_branch_taken,
  input  logic             dmem_access,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_hold,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             id_ex_bubble,
  output logic             flush_front,
  output logic             mem_timeout,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RUN      = 3'd1,
    MEM_WAIT = 3'd2,
    ERROR    = 3'd3
  } state_t;

  localparam int TW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(MEM_TIMEOUT - 1);

  state_t        cur_state;
  state_t        nxt_state;
  logic [TW-1:0] timer;
  logic          timer_clr;
  logic          timer_inc;
  logic          stall_inc;
  logic          flush_inc;
  logic          set_timeout;
  logic          load_use;

  assign load_use = id_ex_memread && (id_ex_rd != 5'd0) &&
                    ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));

  assign state = cur_state;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cur_state   <= IDLE;
      timer       <= '0;
      stall_count <= '0;
      flush_count <= '0;
      mem_timeout <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      if (timer_clr)
        timer <= '0;
      else if (timer_inc)
        timer <= timer + 1'b1;
      if (set_timeout)
        mem_timeout <= 1'b1;
      if (stall_inc && (stall_count != '1))
        stall_count <= stall_count + 1'b1;
      if (flush_inc && (flush_count != '1))
        flush_count <= flush_count + 1'b1;
    end
  end

  // Outputs are combinational so every hazard response lands in the same cycle it is seen.
  always_comb begin
    nxt_state    = cur_state;
    timer_clr    = 1'b0;
    timer_inc    = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    set_timeout  = 1'b0;
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    if_id_hold   = 1'b0;
    id_ex_en     = 1'b0;
    ex_mem_en    = 1'b0;
    mem_wb_en    = 1'b0;
    id_ex_bubble = 1'b0;
    flush_front  = 1'b0;
    if (!arst) begin
      case (cur_state)
        IDLE: begin
          if (start)
            nxt_state = RUN;
        end
        RUN, MEM_WAIT: begin
          if (cur_state == RUN && dmem_access && !dmem_ready) begin
            nxt_state = MEM_WAIT;
            timer_clr = 1'b1;
          end else if (cur_state == MEM_WAIT && !dmem_ready) begin
            if (timer == TIMER_LAST) begin
              nxt_state   = ERROR;
              set_timeout = 1'b1;
            end else begin
              timer_inc = 1'b1;
            end
          end else begin
            // A running cycle: a taken branch squashes the front end, so it outranks load-use.
            pc_en     = 1'b1;
            if_id_en  = 1'b1;
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
            mem_wb_en = 1'b1;
            if (mem_branch_taken) begin
              flush_front = 1'b1;
              flush_inc   = 1'b1;
            end else if (load_use) begin
              pc_en        = 1'b0;
              if_id_en     = 1'b0;
              if_id_hold   = 1'b1;
              id_ex_bubble = 1'b1;
              stall_inc    = 1'b1;
            end
            nxt_state = halt ? IDLE : RUN;
          end
        end
        ERROR: begin
          nxt_state = ERROR;
        end
        default: begin
          nxt_state = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios with literal expectations, then random
// traffic compared every cycle against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;
  localparam int TO = 15;
  localparam int CW = 4;

  logic          clk;
  logic          arst;
  logic          start;
  logic          halt;
  logic          id_ex_memread;
  logic [4:0]    id_ex_rd;
  logic [4:0]    if_id_rs1;
  logic [4:0]    if_id_rs2;
  logic          mem_branch_taken;
  logic          dmem_access;
  logic          dmem_ready;
  logic          pc_en;
  logic          if_id_en;
  logic          if_id_hold;
  logic          id_ex_en;
  logic          ex_mem_en;
  logic          mem_wb_en;
  logic          id_ex_bubble;
  logic          flush_front;
  logic          mem_timeout;
  logic [2:0]    state;
  logic [CW-1:0] stall_count;
  logic [CW-1:0] flush_count;

  int n_tests = 0;
  int n_fail  = 0;
  logic cmp_en = 1'b0;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .arst(arst), .start(start), .halt(halt),
    .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
    .mem_branch_taken(mem_branch_taken), .dmem_access(dmem_access), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_hold(if_id_hold), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en), .id_ex_bubble(id_ex_bubble),
    .flush_front(flush_front), .mem_timeout(mem_timeout), .state(state),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [19:0] dut_vec;
  logic [4:0]  en5;
  assign dut_vec = {pc_en, if_id_en, if_id_hold, id_ex_en, ex_mem_en, mem_wb_en,
                    id_ex_bubble, flush_front, mem_timeout, state, stall_count, flush_count};
  assign en5 = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};

  // behavioural model: mode 0 idle, 1 run, 2 waiting on memory, 3 error
  int m_mode   = 0;
  int m_lows   = 0;
  int m_stalls = 0;
  int m_flush  = 0;
  logic m_err  = 1'b0;

  logic        progress;
  logic        hazard;
  logic        e_flush;
  logic        e_lu;
  logic [19:0] exp_vec;

  always_comb begin
    hazard   = id_ex_memread && id_ex_rd != 5'd0 &&
               (id_ex_rd == if_id_rs1 || id_ex_rd == if_id_rs2);
    progress = !arst && ((m_mode == 1 && !(dmem_access && !dmem_ready)) ||
                         (m_mode == 2 && dmem_ready));
    e_flush  = progress && mem_branch_taken;
    e_lu     = progress && !mem_branch_taken && hazard;
    exp_vec  = {progress && !e_lu, progress && !e_lu, e_lu, progress, progress, progress,
                e_lu, e_flush, m_err, 3'(m_mode), CW'(m_stalls), CW'(m_flush)};
  end

  always @(posedge clk or posedge arst) begin
    if (arst) begin
      m_mode <= 0; m_lows <= 0; m_stalls <= 0; m_flush <= 0; m_err <= 1'b0;
    end else if (m_mode == 0) begin
      if (start) m_mode <= 1;
    end else if (m_mode == 1 && dmem_access && !dmem_ready) begin
      m_mode <= 2; m_lows <= 0;
    end else if (m_mode == 2 && !dmem_ready) begin
      if (m_lows + 1 == TO) begin m_mode <= 3; m_err <= 1'b1; end
      else m_lows <= m_lows + 1;
    end else if (m_mode != 3) begin
      if (e_flush) m_flush <= (m_flush < 2**CW - 1) ? m_flush + 1 : m_flush;
      else if (e_lu) m_stalls <= (m_stalls < 2**CW - 1) ? m_stalls + 1 : m_stalls;
      m_mode <= halt ? 0 : 1;
    end
  end

  // scoreboard
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (cmp_en) chk("cycle_model", 32'(dut_vec), 32'(exp_vec));

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start = 0; halt = 0; id_ex_memread = 0; id_ex_rd = 0; if_id_rs1 = 0; if_id_rs2 = 0;
    mem_branch_taken = 0; dmem_access = 0; dmem_ready = 0;
  endtask

  int low_run;

  initial begin
    clear_inputs();
    arst = 0;
    #1 arst = 1;
    #1 cmp_en = 1'b1;
    chk("reset_outputs", 32'(dut_vec), 32'd0);
    cyc(); cyc(); arst = 0;

    start = 1; #1 chk("idle_state", 32'(state), 32'd0);
    cyc(); start = 0; #1 chk("run_state", 32'(state), 32'd1);
    chk("run_enables", 32'(en5), 32'h1f);

    id_ex_memread = 1; id_ex_rd = 5; if_id_rs2 = 5;
    #1 chk("lu_outputs", 32'({pc_en, if_id_en, if_id_hold, id_ex_en, id_ex_bubble}), 32'b00111);
    cyc(); id_ex_memread = 0; #1 chk("lu_stall_count", 32'(stall_count), 32'd1);
    id_ex_memread = 1; id_ex_rd = 0; if_id_rs2 = 0;
    #1 chk("lu_rd0", 32'({pc_en, if_id_hold, id_ex_bubble}), 32'b100);
    cyc(); #1 chk("lu_rd0_count", 32'(stall_count), 32'd1);

    id_ex_rd = 5; if_id_rs2 = 5; mem_branch_taken = 1;
    #1 chk("flush_over_lu", 32'({flush_front, id_ex_bubble, pc_en}), 32'b101);
    cyc(); mem_branch_taken = 0; id_ex_memread = 0;
    #1 chk("flush_count", 32'(flush_count), 32'd1);
    chk("stall_after_flush", 32'(stall_count), 32'd1);

    dmem_access = 1; dmem_ready = 0; #1 chk("freeze_run", 32'(en5), 32'd0);
    cyc(); #1 chk("wait1_state", 32'(state), 32'd2);
    chk("wait1_en", 32'(en5), 32'd0);
    cyc(); #1 chk("wait2_en", 32'(en5), 32'd0);
    dmem_ready = 1; #1 chk("wait_release_en", 32'(en5), 32'h1f);
    cyc(); dmem_access = 0; #1 chk("after_wait_state", 32'(state), 32'd1);

    dmem_access = 1; dmem_ready = 0;
    cyc(); dmem_access = 0;
    for (int i = 0; i < 14; i++) cyc();
    #1 chk("wait15_state", 32'({state, mem_timeout}), 32'({3'd2, 1'b0}));
    cyc(); #1 chk("error_state", 32'({state, mem_timeout}), 32'({3'd3, 1'b1}));
    dmem_ready = 1; start = 1;
    cyc(); cyc(); start = 0;
    #1 chk("error_sticky", 32'({state, mem_timeout, en5}), 32'({3'd3, 1'b1, 5'd0}));

    arst = 1; cyc(); arst = 0;
    start = 1; cyc(); start = 0;
    id_ex_memread = 1; id_ex_rd = 3; if_id_rs1 = 3; cyc(); id_ex_memread = 0;
    mem_branch_taken = 1; cyc(); mem_branch_taken = 0;
    dmem_access = 1; dmem_ready = 0; cyc();
    for (int i = 0; i < 4; i++) cyc();
    #1 chk("wait5_state", 32'({state, stall_count, flush_count}), 32'({3'd2, 4'd1, 4'd1}));
    arst = 1;
    #1 chk("async_reset", 32'({state, stall_count, flush_count}), 32'd0);
    chk("async_reset_outputs", 32'(dut_vec), 32'd0);
    cyc(); arst = 0; dmem_access = 0; dmem_ready = 1; start = 1;
    cyc(); start = 0; #1 chk("resume_run", 32'(state), 32'd1);

    halt = 1; cyc(); halt = 0; #1 chk("halt_idle", 32'(state), 32'd0);
    start = 1; cyc(); start = 0;
    halt = 1; dmem_access = 1; dmem_ready = 0;
    cyc(); halt = 0; #1 chk("halt_frozen", 32'(state), 32'd2);
    dmem_ready = 1; cyc(); dmem_access = 0; #1 chk("halt_frozen_run", 32'(state), 32'd1);

    id_ex_memread = 1; id_ex_rd = 7; if_id_rs1 = 7;
    for (int i = 0; i < 20; i++) cyc();
    #1 chk("stall_sat", 32'(stall_count), 32'd15);
    id_ex_memread = 0; mem_branch_taken = 1;
    for (int i = 0; i < 20; i++) cyc();
    #1 chk("flush_sat", 32'(flush_count), 32'd15);
    mem_branch_taken = 0;

    low_run = 0;
    for (int n = 0; n < 3000; n++) begin
      arst             = ($urandom_range(0, 299) == 0);
      start            = ($urandom_range(0, 9) == 0);
      halt             = ($urandom_range(0, 29) == 0);
      id_ex_memread    = ($urandom_range(0, 2) == 0);
      id_ex_rd         = 5'($urandom_range(0, 3));
      if_id_rs1        = 5'($urandom_range(0, 3));
      if_id_rs2        = 5'($urandom_range(0, 3));
      mem_branch_taken = ($urandom_range(0, 5) == 0);
      dmem_access      = ($urandom_range(0, 3) == 0);
      if (low_run > 0) begin
        dmem_ready = 0;
        low_run--;
      end else begin
        dmem_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 149) == 0) low_run = 18;
      end
      cyc();
    end
    arst = 0;
    clear_inputs();
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
